// File: rtl/pid_pkg.sv
// Shared definitions for the PID loop sequencer and the PID_controller it talks to.
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_I2F    = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_F2I    = 3'd5,
    S_OUTPUT = 3'd6
  } seq_state_t;

  localparam logic [7:0] EXP_BIAS    = 8'd127;
  localparam logic [7:0] EXP_NAN_INF = 8'd255;
  localparam int         MANT_W      = 23;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_I2F = 3'd3;
  localparam logic [2:0] OP_F2I = 3'd4;

endpackage

// File: rtl/float_int_convert.sv
// Combinational int32 -> IEEE single (truncating) and IEEE single -> saturated int32.
// Zero latency; no flow control, callers register the outputs.
module float_int_convert
  import pid_pkg::*;
#(
  parameter int PWM_MAX = 4000
) (
  input  logic [31:0] int_in,
  output logic [31:0] float_out,
  input  logic [31:0] float_in,
  output logic [31:0] int_out
);

  localparam logic [31:0] LIM = PWM_MAX[31:0];

  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  msb;

  always_comb begin
    mag = int_in[31] ? (~int_in + 32'd1) : int_in;
    msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = i[4:0];
    end
    norm = mag << (5'd31 - msb);
    if (mag == 32'd0) begin
      float_out = 32'd0;
    end else begin
      float_out = {int_in[31], EXP_BIAS + {3'b000, msb}, norm[30 -: MANT_W]};
    end
  end

  logic        f_sign;
  logic [7:0]  f_exp;
  logic [22:0] f_mant;
  logic [7:0]  sh;
  logic [31:0] sig;
  logic [31:0] mag_f;
  logic [31:0] lim_mag;
  logic        sat;
  logic        zero;

  always_comb begin
    f_sign = float_in[31];
    f_exp  = float_in[30:23];
    f_mant = float_in[22:0];
    sat    = 1'b0;
    zero   = 1'b0;
    sh     = 8'd0;
    sig    = {8'd0, 1'b1, f_mant};
    mag_f  = 32'd0;
    if (f_exp == 8'd0) begin
      zero = 1'b1;
    end else if (f_exp == EXP_NAN_INF) begin
      if (f_mant != 23'd0) zero = 1'b1;
      else                 sat  = 1'b1;
    end else if (f_exp < EXP_BIAS) begin
      zero = 1'b1;
    end else if (f_exp >= EXP_BIAS + 8'd31) begin
      sat = 1'b1;
    end else begin
      // Unbiased exponent is 0..30 here, so the shifted value fits in 31 bits.
      sh = f_exp - EXP_BIAS;
      if (sh >= 8'(MANT_W)) mag_f = sig << (sh - 8'(MANT_W));
      else                  mag_f = sig >> (8'(MANT_W) - sh);
      if (mag_f > LIM) sat = 1'b1;
    end
    lim_mag = sat ? LIM : (zero ? 32'd0 : mag_f);
    int_out = f_sign ? (~lim_mag + 32'd1) : lim_mag;
  end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Periodic sample -> float -> PID update -> float result -> saturated pwm sequencer.
// Tick to update_controller 3 cycles, pwm_valid RESULT_LATENCY+3 later; ticks while busy are counted and dropped.
module pid_loop_sequencer
  import pid_pkg::*;
#(
  parameter int PERIOD         = 50000,
  parameter int RESULT_LATENCY = 40,
  parameter int PWM_MAX        = 4000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] position,
  input  logic [31:0] result,
  output logic [31:0] state,
  output logic        update_controller,
  output logic [31:0] pwm,
  output logic        pwm_valid,
  output logic        busy,
  output logic [15:0] overrun_count
);

  localparam int CW = $clog2(PERIOD);
  localparam int WW = $clog2(RESULT_LATENCY + 1);

  seq_state_t  fsm_q, fsm_d;
  logic [CW-1:0] period_cnt;
  logic [WW-1:0] wait_cnt;
  logic          tick;
  logic [31:0]   pos_q;
  logic [31:0]   res_q;
  logic [31:0]   conv_float;
  logic [31:0]   conv_int;

  assign tick = (period_cnt == CW'(PERIOD - 1));

  float_int_convert #(.PWM_MAX(PWM_MAX)) u_conv (
    .int_in    (pos_q),
    .float_out (conv_float),
    .float_in  (res_q),
    .int_out   (conv_int)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) period_cnt <= '0;
    else       period_cnt <= tick ? '0 : period_cnt + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:   if (tick && enable) fsm_d = S_SAMPLE;
      S_SAMPLE: fsm_d = S_I2F;
      S_I2F:    fsm_d = S_ISSUE;
      S_ISSUE:  fsm_d = S_WAIT;
      S_WAIT:   if (wait_cnt == WW'(1)) fsm_d = S_F2I;
      S_F2I:    fsm_d = S_OUTPUT;
      S_OUTPUT: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q         <= '0;
      res_q         <= '0;
      state         <= '0;
      wait_cnt      <= '0;
      pwm           <= '0;
      pwm_valid     <= 1'b0;
      overrun_count <= '0;
    end else begin
      pwm_valid <= 1'b0;
      case (fsm_q)
        S_SAMPLE: pos_q    <= position;
        S_I2F:    state    <= conv_float;
        S_ISSUE:  wait_cnt <= WW'(RESULT_LATENCY);
        S_WAIT:   wait_cnt <= wait_cnt - WW'(1);
        S_F2I:    res_q    <= result;
        S_OUTPUT: begin
          pwm       <= conv_int;
          pwm_valid <= 1'b1;
        end
        default: ;
      endcase
      if (tick && fsm_q != S_IDLE && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end
  end

  assign update_controller = (fsm_q == S_ISSUE);
  assign busy              = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench: instance a (PERIOD 16, latency 4, PWM_MAX 500) and instance o (PERIOD 8, latency 20).
module tb_pid_loop_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en_a = 1'b0, en_o = 1'b0;
  logic [31:0] pos_a = '0, res_a = '0, pos_o = '0, res_o = '0;
  logic [31:0] state_a, state_o, pwm_a, pwm_o;
  logic        upd_a, upd_o, pv_a, pv_o, busy_a, busy_o;
  logic [15:0] ov_a, ov_o;
  int          total = 0;
  int          bad = 0;
  int          cyc;

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  pid_loop_sequencer #(.PERIOD(16), .RESULT_LATENCY(4), .PWM_MAX(500)) dut_a (
    .clock(clock), .reset(reset), .enable(en_a), .position(pos_a), .result(res_a),
    .state(state_a), .update_controller(upd_a), .pwm(pwm_a), .pwm_valid(pv_a),
    .busy(busy_a), .overrun_count(ov_a)
  );

  pid_loop_sequencer #(.PERIOD(8), .RESULT_LATENCY(20), .PWM_MAX(4000)) dut_o (
    .clock(clock), .reset(reset), .enable(en_o), .position(pos_o), .result(res_o),
    .state(state_o), .update_controller(upd_o), .pwm(pwm_o), .pwm_valid(pv_o),
    .busy(busy_o), .overrun_count(ov_o)
  );

  localparam int NV = 11;
  localparam logic [31:0] V_POS [NV] = '{32'd10, 32'hFFFFFFF6, 32'd0, 32'h80000000, 32'h7FFFFFFF,
                                         32'd1, 32'd3, 32'd100, 32'hFFFFFFFF, 32'd2, 32'd5};
  localparam logic [31:0] V_RES [NV] = '{32'h3FC00000, 32'h457A0000, 32'hC57A0000, 32'hC1200000, 32'h7FC00000,
                                         32'hFF800000, 32'h80000000, 32'h42C80000, 32'h00400000, 32'h3F000000,
                                         32'h7F800000};
  localparam logic [31:0] V_ST  [NV] = '{32'h41200000, 32'hC1200000, 32'h00000000, 32'hCF000000, 32'h4EFFFFFF,
                                         32'h3F800000, 32'h40400000, 32'h42C80000, 32'hBF800000, 32'h40000000,
                                         32'h40A00000};
  localparam logic [31:0] V_PWM [NV] = '{32'd1, 32'd500, 32'hFFFFFE0C, 32'hFFFFFFF6, 32'd0,
                                         32'hFFFFFE0C, 32'd0, 32'd100, 32'd0, 32'd0, 32'd500};

  // Runs one loop on instance a; du = counter phase at the update pulse, dv = cycles to pwm_valid.
  task automatic run_one(input logic [31:0] pos, input logic [31:0] res,
                         output logic [31:0] st, output logic [31:0] pw,
                         output int du, output int dv, output logic upd2);
    int n;
    pos_a = pos;
    res_a = res;
    st = 'x; pw = 'x; du = -1; dv = -1; upd2 = 1'bx;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!upd_a && n < 40);
    if (!upd_a) return;
    st = state_a;
    du = cyc % 16;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) upd2 = upd_a;
    end while (!pv_a && n < 40);
    if (!pv_a) return;
    dv = n;
    pw = pwm_a;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++; if (state_a !== 32'd0) begin bad++; $display("FAIL reset_state got=%h want=0", state_a); end
    total++; if (upd_a !== 1'b0) begin bad++; $display("FAIL reset_update got=%b want=0", upd_a); end
    total++; if (pwm_a !== 32'd0) begin bad++; $display("FAIL reset_pwm got=%h want=0", pwm_a); end
    total++; if (pv_a !== 1'b0) begin bad++; $display("FAIL reset_pwm_valid got=%b want=0", pv_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    total++; if (ov_a !== 16'd0) begin bad++; $display("FAIL reset_overrun got=%h want=0", ov_a); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    en_a = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] st, pw;
    int du, dv;
    logic u2;
    run_one(V_POS[0], V_RES[0], st, pw, du, dv, u2);
    total++; if (du !== 2) begin bad++; $display("FAIL basic_tick_to_update phase got=%0d want=2", du); end
    total++; if (st !== V_ST[0]) begin bad++; $display("FAIL basic_state got=%h want=%h", st, V_ST[0]); end
    total++; if (u2 !== 1'b0) begin bad++; $display("FAIL basic_update_width got=%b want=0", u2); end
    total++; if (dv !== 7) begin bad++; $display("FAIL basic_update_to_valid got=%0d want=7", dv); end
    total++; if (pw !== V_PWM[0]) begin bad++; $display("FAIL basic_pwm got=%h want=%h", pw, V_PWM[0]); end
  endtask

  task automatic test_conversions();
    logic [31:0] st, pw;
    int du, dv;
    logic u2;
    for (int i = 1; i < NV; i++) begin
      run_one(V_POS[i], V_RES[i], st, pw, du, dv, u2);
      total++;
      if (st !== V_ST[i]) begin bad++; $display("FAIL conv_state[%0d] got=%h want=%h", i, st, V_ST[i]); end
      total++;
      if (pw !== V_PWM[i]) begin bad++; $display("FAIL conv_pwm[%0d] got=%h want=%h", i, pw, V_PWM[i]); end
    end
  endtask

  task automatic test_overrun();
    int n, t1, t2, upds;
    en_a = 1'b0;
    pos_o = 32'd5;
    res_o = 32'h40A00000;
    @(negedge clock);
    en_o = 1'b1;
    upds = 0; n = 0;
    do begin
      @(negedge clock);
      n++;
      if (upd_o) upds++;
    end while (!pv_o && n < 60);
    t1 = cyc;
    total++; if (!pv_o) begin bad++; $display("FAIL overrun_first_valid got=timeout want=pulse"); end
    total++; if (ov_o !== 16'd3) begin bad++; $display("FAIL overrun_count_1 got=%0d want=3", ov_o); end
    total++; if (pwm_o !== 32'd5) begin bad++; $display("FAIL overrun_pwm got=%h want=5", pwm_o); end
    @(negedge clock);
    total++; if (pv_o !== 1'b0) begin bad++; $display("FAIL overrun_valid_width got=%b want=0", pv_o); end
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (upd_o) upds++;
    end while (!pv_o && n < 60);
    t2 = cyc;
    en_o = 1'b0;
    total++; if (t2 - t1 !== 32) begin bad++; $display("FAIL overrun_loop_gap got=%0d want=32", t2 - t1); end
    total++; if (ov_o !== 16'd6) begin bad++; $display("FAIL overrun_count_2 got=%0d want=6", ov_o); end
    total++; if (upds !== 2) begin bad++; $display("FAIL overrun_update_count got=%0d want=2", upds); end
  endtask

  task automatic test_enable();
    logic [31:0] hold;
    int n, upds, changes, t0;
    en_a = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin @(negedge clock); n++; end
    hold = pwm_a;
    upds = 0; changes = 0;
    repeat (48) begin
      @(negedge clock);
      if (upd_a) upds++;
      if (pwm_a !== hold) changes++;
    end
    total++; if (upds !== 0) begin bad++; $display("FAIL disabled_updates got=%0d want=0", upds); end
    total++; if (changes !== 0) begin bad++; $display("FAIL disabled_pwm_hold got=%0d changes want=0", changes); end
    pos_a = 32'd7;
    res_a = 32'hC1200000;
    n = 0;
    while (cyc % 16 != 7 && n < 20) begin @(negedge clock); n++; end
    en_a = 1'b1;
    t0 = cyc;
    n = 0;
    do begin @(negedge clock); n++; end while (!upd_a && n < 40);
    total++; if (cyc - t0 !== 11) begin bad++; $display("FAIL enable_first_update got=%0d want=11", cyc - t0); end
    n = 0;
    do begin @(negedge clock); n++; end while (!pv_a && n < 40);
    total++; if (pwm_a !== 32'hFFFFFFF6) begin bad++; $display("FAIL enable_pwm got=%h want=fffffff6", pwm_a); end
  endtask

  task automatic test_async_reset();
    logic [31:0] st, pw;
    int n, du, dv;
    logic u2;
    pos_a = 32'd10;
    res_a = 32'h3FC00000;
    n = 0;
    do begin @(negedge clock); n++; end while (!upd_a && n < 40);
    repeat (2) @(negedge clock);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rst_precond_busy got=%b want=1", busy_a); end
    #1 reset = 1'b1;
    #1;
    total++; if (state_a !== 32'd0) begin bad++; $display("FAIL rst_state got=%h want=0", state_a); end
    total++; if (pwm_a !== 32'd0) begin bad++; $display("FAIL rst_pwm got=%h want=0", pwm_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_a); end
    total++; if (ov_o !== 16'd0) begin bad++; $display("FAIL rst_overrun got=%0d want=0", ov_o); end
    total++; if (pwm_o !== 32'd0) begin bad++; $display("FAIL rst_pwm_o got=%h want=0", pwm_o); end
    @(negedge clock);
    reset = 1'b0;
    run_one(32'd10, 32'h3FC00000, st, pw, du, dv, u2);
    total++; if (du !== 2) begin bad++; $display("FAIL rst_resume_phase got=%0d want=2", du); end
    total++; if (st !== 32'h41200000) begin bad++; $display("FAIL rst_resume_state got=%h want=41200000", st); end
    total++; if (dv !== 7) begin bad++; $display("FAIL rst_resume_latency got=%0d want=7", dv); end
    total++; if (pw !== 32'd1) begin bad++; $display("FAIL rst_resume_pwm got=%h want=1", pw); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conversions();
    test_overrun();
    test_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_loop_sequencer.md
Name: pid_loop_sequencer

Overview:
Drives the setpoint-independent side of the PID_controller interface: it periodically samples an integer sensor position, converts it to IEEE-754 single, presents it as `state`, and pulses `update_controller`. After a fixed wait it captures the float `result`, converts it to a saturated signed integer drive command, and flags that command valid. It sits between the encoder/position logic and the motor PWM generator, one instance per motor.

Parameters:
PERIOD, 50000, control-loop period in clock cycles (>= 8)
RESULT_LATENCY, 40, cycles waited after the update pulse before `result` is sampled (>= 1)
PWM_MAX, 4000, positive saturation magnitude of `pwm`; the negative limit is -PWM_MAX

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  loop enable; while low no new cycle starts
position  in  32  signed integer sensor position
result  in  32  IEEE-754 single from PID_controller
state  out  32  IEEE-754 single of the sampled position, to PID_controller
update_controller  out  1  one-cycle pulse to PID_controller
pwm  out  32  signed, saturated drive command
pwm_valid  out  1  one-cycle pulse when `pwm` updates
busy  out  1  high whenever the FSM is not in IDLE
overrun_count  out  16  count of skipped ticks, saturates at 0xFFFF

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; period counter 0.
- Period counter:
  - Free-runs from 0 to PERIOD-1 and wraps.
  - A tick occurs in the cycle where the counter equals PERIOD-1.
  - The counter keeps running regardless of `enable` or FSM state.
- FSM states: IDLE, SAMPLE, I2F, ISSUE, WAIT, F2I, OUTPUT.
- IDLE -> SAMPLE on a tick with `enable`=1; otherwise stay in IDLE.
- SAMPLE (1 cycle): register `position`.
- I2F (1 cycle): register the converted float into `state`.
- ISSUE (1 cycle): `update_controller`=1. This is the only cycle it is high. `state` is stable from this cycle until the next I2F.
- WAIT: a down-counter is loaded with RESULT_LATENCY. Go to F2I after exactly RESULT_LATENCY cycles in WAIT.
- F2I (1 cycle): register `result` and compute the integer value.
- OUTPUT (1 cycle): update `pwm`, pulse `pwm_valid`=1, then return to IDLE.
- Latency from tick to `update_controller`: 3 cycles. `pwm_valid` asserts RESULT_LATENCY+3 cycles after `update_controller`.
- Overrun: a tick while not in IDLE increments `overrun_count` (saturating) and is otherwise ignored; the current cycle completes normally.
- Deasserting `enable` mid-cycle lets the current cycle finish. `pwm` holds its last value while disabled.
- Asynchronous `reset` mid-operation returns every output and register to its reset value immediately.
- Int-to-float conversion (signed 32-bit in):
  - 0 maps to 0x00000000.
  - Sign comes from bit 31.
  - Magnitude is the two's-complement absolute value, held as an unsigned 32-bit value, so -2^31 maps to 0xCF000000.
  - Exponent is 127 + index of the MSB of the magnitude.
  - Mantissa is the next 23 bits below the MSB, truncated (round toward zero).
  - The leading-zero count is combinational, so the conversion completes in the I2F cycle.
- Float-to-int conversion:
  - Exponent field 0 (zero or denormal) maps to 0.
  - NaN (exponent 255, mantissa nonzero) maps to 0.
  - ±Inf saturates to ±PWM_MAX.
  - Otherwise the value is truncated toward zero.
  - Any magnitude >= 2^31, or a truncated value beyond ±PWM_MAX, clamps to ±PWM_MAX.
  - Negative zero maps to 0.

Decomposition:
- Shared package pid_pkg holds:
  - FSM state enum type
  - float field constants: EXP_BIAS=127, EXP_NAN_INF=255, MANT_W=23
  - opcode localparams ADD..F2I for shared use with PID_controller
- Sub-module float_int_convert holds both combinational converters (int2float and float2int_sat, PWM_MAX parameter). It is instantiated once; the FSM registers its outputs.

Test Plan:
- PERIOD=16, RESULT_LATENCY=4, enable=1, position=10:
  - `state`=0x41200000 when `update_controller` pulses, 3 cycles after the tick.
  - Drive `result`=0x3FC00000 (1.5) -> `pwm`=1 with `pwm_valid` 7 cycles after `update_controller`.
- Position conversions:
  - position=-10 -> `state`=0xC1200000
  - position=0 -> 0x00000000
  - position=0x80000000 -> 0xCF000000
  - position=0x7FFFFFFF -> 0x4EFFFFFF (truncated)
- Result conversions:
  - 0x457A0000 (4000) with PWM_MAX=500 -> `pwm`=500
  - 0xC57A0000 -> -500
  - 0xC1200000 -> -10
  - 0x7FC00000 (NaN) -> 0
  - 0xFF800000 -> -500
- Overrun: PERIOD=8, RESULT_LATENCY=20, run 3 periods -> `overrun_count` increments once per tick landing outside IDLE, and each completed loop gives exactly one `pwm_valid`.
- Enable low: no `update_controller` pulses over 3 periods and `pwm` holds. Raise enable mid-period -> first pulse comes 3 cycles after the next tick.
- Reset asserted during WAIT -> all outputs 0 in the same cycle, without waiting for a clock edge. After release, normal operation resumes from the next tick.
